// File: rtl/fetch_unit.sv
// fetch_unit: PC and IR stage that turns the controller's held strobes into single actions and fetches words over req/ack.
module fetch_unit #(
  parameter int ADDR_W  = 6,
  parameter int INSTR_W = 12,
  parameter int TIMEOUT = 255
) (
  input  logic               CLK,
  input  logic               Reset_in,
  input  logic               PC_INC,
  input  logic               PC_LOAD,
  input  logic               IR_WR,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic [4:0]         opCode,
  output logic               D,
  output logic [5:0]         operand,
  output logic               ir_valid,
  output logic               busy,
  output logic               fetch_fault
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state;
  logic [INSTR_W-1:0] ir;
  logic [CW-1:0] cnt;
  logic prev_inc, prev_load, prev_fetch;
  logic inc_ev, load_ev, fetch_ev;
  assign inc_ev   = PC_INC & ~prev_inc;
  assign load_ev  = ~PC_LOAD & prev_load;
  assign fetch_ev = IR_WR & ~prev_fetch;
  assign opCode   = ir[11:7];
  assign D        = ir[6];
  assign operand  = ir[5:0];
  assign busy     = state == REQ;
  always_ff @(posedge CLK) begin
    if (Reset_in) begin
      pc          <= '0;
      ir          <= '0;
      ir_valid    <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      fetch_fault <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      // Preload history with live levels so a strobe held across reset does not fire
      prev_inc    <= PC_INC;
      prev_load   <= PC_LOAD;
      prev_fetch  <= IR_WR;
    end else begin
      prev_inc   <= PC_INC;
      prev_load  <= PC_LOAD;
      prev_fetch <= IR_WR;
      if (load_ev) pc <= jump_addr;
      else if (inc_ev) pc <= pc + 1'b1;
      case (state)
        IDLE: if (fetch_ev) begin
          state     <= REQ;
          imem_req  <= 1'b1;
          imem_addr <= pc;
          cnt       <= '0;
        end
        REQ: if (imem_ack) begin
          ir       <= imem_rdata;
          ir_valid <= 1'b1;
          imem_req <= 1'b0;
          state    <= IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          fetch_fault <= 1'b1;
          imem_req    <= 1'b0;
          state       <= IDLE;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table for PC strobes plus hand sequences for fetch, timeout and reset corners.
module tb_fetch_unit;
  localparam int TIMEOUT = 255;
  logic clk = 1'b0, rst = 1'b1;
  logic pc_inc = 1'b0, pc_load = 1'b1, ir_wr = 1'b0, ack = 1'b0;
  logic [5:0] jump = '0;
  logic [11:0] rdata = '0;
  logic req, busy, d, ir_valid, fault;
  logic [5:0] addr, pc, operand;
  logic [4:0] op;
  int checks = 0, errors = 0, rises = 0, base;
  logic req_d = 1'b0;
  fetch_unit #(.ADDR_W(6), .INSTR_W(12), .TIMEOUT(TIMEOUT)) dut (
    .CLK(clk), .Reset_in(rst), .PC_INC(pc_inc), .PC_LOAD(pc_load), .IR_WR(ir_wr),
    .jump_addr(jump), .imem_ack(ack), .imem_rdata(rdata), .imem_req(req),
    .imem_addr(addr), .pc(pc), .opCode(op), .D(d), .operand(operand),
    .ir_valid(ir_valid), .busy(busy), .fetch_fault(fault)
  );
  always #10 clk = ~clk;
  always @(posedge clk) begin
    req_d <= req;
    if (req && !req_d) rises++;
  end
  typedef struct {
    logic inc;
    logic load;
    logic [5:0] jmp;
    logic [5:0] exp_pc;
  } vec_t;
  vec_t vecs[13];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    vecs[0]  = '{1'b1, 1'b1, 6'h00, 6'h02};
    vecs[1]  = '{1'b1, 1'b1, 6'h00, 6'h02};
    vecs[2]  = '{1'b0, 1'b1, 6'h00, 6'h02};
    vecs[3]  = '{1'b1, 1'b1, 6'h00, 6'h03};
    vecs[4]  = '{1'b0, 1'b0, 6'h2A, 6'h2A};
    vecs[5]  = '{1'b0, 1'b0, 6'h10, 6'h2A};
    vecs[6]  = '{1'b0, 1'b1, 6'h10, 6'h2A};
    vecs[7]  = '{1'b1, 1'b0, 6'h3F, 6'h3F};
    vecs[8]  = '{1'b0, 1'b1, 6'h3F, 6'h3F};
    vecs[9]  = '{1'b1, 1'b1, 6'h00, 6'h00};
    vecs[10] = '{1'b0, 1'b1, 6'h00, 6'h00};
    vecs[11] = '{1'b1, 1'b0, 6'h2A, 6'h2A};
    vecs[12] = '{1'b0, 1'b1, 6'h2A, 6'h2A};
    tick();
    tick();
    rst = 1'b0;
    check("rst_pc", pc, 0);
    check("rst_op", op, 0);
    check("rst_valid", ir_valid, 0);
    check("rst_req", req, 0);
    check("rst_fault", fault, 0);
    check("rst_busy", busy, 0);
    pc_inc = 1'b1;
    tick();
    check("inc_once", pc, 1);
    for (int i = 0; i < 19; i++) tick();
    check("inc_held", pc, 1);
    pc_inc = 1'b0;
    tick();
    for (int i = 0; i < 13; i++) begin
      pc_inc = vecs[i].inc;
      pc_load = vecs[i].load;
      jump = vecs[i].jmp;
      tick();
      check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_addr", i), addr, 0);
    end
    pc_inc = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("inc_held_thru_rst", pc, 0);
    pc_inc = 1'b0;
    tick();
    base = rises;
    ir_wr = 1'b1;
    tick();
    check("fetch_req", req, 1);
    check("fetch_busy", busy, 1);
    check("fetch_addr", addr, 0);
    tick();
    tick();
    check("fetch_wait_valid", ir_valid, 0);
    ack = 1'b1;
    rdata = 12'b00111_0_000101;
    tick();
    ack = 1'b0;
    rdata = 12'hFFF;
    check("fetch_op", op, 5'b00111);
    check("fetch_d", d, 0);
    check("fetch_operand", operand, 5);
    check("fetch_valid", ir_valid, 1);
    check("fetch_req_drop", req, 0);
    for (int i = 0; i < 6; i++) tick();
    check("fetch_one_req", rises - base, 1);
    check("fetch_idle_busy", busy, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("idle_ack_ignored", op, 5'b00111);
    ir_wr = 1'b0;
    tick();
    ir_wr = 1'b1;
    tick();
    check("to_req", req, 1);
    base = 0;
    while (req && base < 400) begin
      tick();
      base++;
    end
    check("to_cycles", base, TIMEOUT);
    check("to_fault", fault, 1);
    check("to_busy", busy, 0);
    check("to_op_kept", op, 5'b00111);
    check("to_operand_kept", operand, 5);
    check("to_valid_kept", ir_valid, 1);
    ir_wr = 1'b0;
    tick();
    ir_wr = 1'b1;
    tick();
    check("midrst_req", req, 1);
    check("fault_sticky", fault, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    check("midrst_op", op, 0);
    check("midrst_operand", operand, 0);
    check("midrst_valid", ir_valid, 0);
    check("midrst_req_low", req, 0);
    check("midrst_fault_clr", fault, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
